// File: rtl/id_stage_if.sv
// Signal bundle between the ID stage and its IF, register-file, EX/MEM and ID/EX neighbours.
// The slave modport is the decode stage; master is the surrounding pipeline.
interface id_stage_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned REG_ADDR = 5
);
    logic                if_valid;
    logic [XLEN-1:0]     if_pc;
    logic [31:0]         if_inst;
    logic                stall_in;
    logic                flush;

    logic                rf_re1;
    logic                rf_re2;
    logic [REG_ADDR-1:0] rf_raddr1;
    logic [REG_ADDR-1:0] rf_raddr2;
    logic [XLEN-1:0]     rf_rdata1;
    logic [XLEN-1:0]     rf_rdata2;

    logic                ex_we;
    logic [REG_ADDR-1:0] ex_waddr;
    logic [XLEN-1:0]     ex_wdata;
    logic                ex_is_load;
    logic                mem_we;
    logic [REG_ADDR-1:0] mem_waddr;
    logic [XLEN-1:0]     mem_wdata;

    logic                stall_req;
    logic                id_valid;
    logic [XLEN-1:0]     id_pc;
    logic [6:0]          id_opcode;
    logic [2:0]          id_funct3;
    logic                id_funct7b5;
    logic [XLEN-1:0]     id_rs1_val;
    logic [XLEN-1:0]     id_rs2_val;
    logic [XLEN-1:0]     id_imm;
    logic [REG_ADDR-1:0] id_rd;
    logic                id_we;

    modport slave (
        input  if_valid, if_pc, if_inst, stall_in, flush,
        input  rf_rdata1, rf_rdata2,
        input  ex_we, ex_waddr, ex_wdata, ex_is_load,
        input  mem_we, mem_waddr, mem_wdata,
        output rf_re1, rf_re2, rf_raddr1, rf_raddr2,
        output stall_req, id_valid, id_pc, id_opcode, id_funct3, id_funct7b5,
        output id_rs1_val, id_rs2_val, id_imm, id_rd, id_we
    );

    modport master (
        output if_valid, if_pc, if_inst, stall_in, flush,
        output rf_rdata1, rf_rdata2,
        output ex_we, ex_waddr, ex_wdata, ex_is_load,
        output mem_we, mem_waddr, mem_wdata,
        input  rf_re1, rf_re2, rf_raddr1, rf_raddr2,
        input  stall_req, id_valid, id_pc, id_opcode, id_funct3, id_funct7b5,
        input  id_rs1_val, id_rs2_val, id_imm, id_rd, id_we
    );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: register-file read control, EX/MEM operand forwarding,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned REG_ADDR = 5
) (
    input logic        clk,
    input logic        rst,
    id_stage_if.slave  bus
);
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    typedef struct packed {
        logic                valid;
        logic [XLEN-1:0]     pc;
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic                funct7b5;
        logic [XLEN-1:0]     rs1_val;
        logic [XLEN-1:0]     rs2_val;
        logic [XLEN-1:0]     imm;
        logic [REG_ADDR-1:0] rd;
        logic                we;
    } id_ex_t;

    logic [31:0]         inst;
    logic [6:0]          opcode;
    logic [REG_ADDR-1:0] rs1;
    logic [REG_ADDR-1:0] rs2;
    logic [REG_ADDR-1:0] rd;

    logic                legal;
    logic                writes_rd;
    logic                uses_rs1;
    logic                uses_rs2;
    logic [XLEN-1:0]     imm;
    logic                re1;
    logic                re2;
    logic [XLEN-1:0]     rs1_val;
    logic [XLEN-1:0]     rs2_val;
    logic                hazard;

    id_ex_t idex_d;
    id_ex_t idex_q;

    assign inst   = bus.if_inst;
    assign opcode = inst[6:0];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign rd     = inst[11:7];

    always_comb begin
        legal     = 1'b1;
        writes_rd = 1'b0;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b0;
        imm       = '0;
        case (opcode)
            OpLui, OpAuipc: begin
                writes_rd = 1'b1;
                uses_rs1  = 1'b0;
                imm       = {inst[31:12], 12'b0};
            end
            OpJal: begin
                writes_rd = 1'b1;
                uses_rs1  = 1'b0;
                imm       = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OpJalr, OpLoad, OpImm: begin
                writes_rd = 1'b1;
                imm       = {{20{inst[31]}}, inst[31:20]};
            end
            OpBranch: begin
                uses_rs2 = 1'b1;
                imm      = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OpStore: begin
                uses_rs2 = 1'b1;
                imm      = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OpReg: begin
                writes_rd = 1'b1;
                uses_rs2  = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    assign re1           = bus.if_valid & uses_rs1;
    assign re2           = bus.if_valid & uses_rs2;
    assign bus.rf_re1    = re1;
    assign bus.rf_re2    = re2;
    assign bus.rf_raddr1 = rs1;
    assign bus.rf_raddr2 = rs2;

    // EX is younger than MEM, so its result takes precedence.
    always_comb begin
        if (rs1 == '0) begin
            rs1_val = '0;
        end else if (bus.ex_we && bus.ex_waddr == rs1) begin
            rs1_val = bus.ex_wdata;
        end else if (bus.mem_we && bus.mem_waddr == rs1) begin
            rs1_val = bus.mem_wdata;
        end else begin
            rs1_val = bus.rf_rdata1;
        end

        if (rs2 == '0) begin
            rs2_val = '0;
        end else if (bus.ex_we && bus.ex_waddr == rs2) begin
            rs2_val = bus.ex_wdata;
        end else if (bus.mem_we && bus.mem_waddr == rs2) begin
            rs2_val = bus.mem_wdata;
        end else begin
            rs2_val = bus.rf_rdata2;
        end
    end

    assign hazard = bus.if_valid & ~bus.flush & bus.ex_is_load & bus.ex_we &
                    (bus.ex_waddr != '0) &
                    ((re1 & (bus.ex_waddr == rs1)) | (re2 & (bus.ex_waddr == rs2)));
    assign bus.stall_req = hazard;

    always_comb begin
        idex_d = idex_q;
        if (bus.flush) begin
            idex_d = '0;
        end else if (!bus.stall_in) begin
            if (hazard || !(bus.if_valid && legal)) begin
                idex_d = '0;
            end else begin
                idex_d.valid    = 1'b1;
                idex_d.pc       = bus.if_pc;
                idex_d.opcode   = opcode;
                idex_d.funct3   = inst[14:12];
                idex_d.funct7b5 = inst[30];
                idex_d.rs1_val  = rs1_val;
                idex_d.rs2_val  = rs2_val;
                idex_d.imm      = imm;
                idex_d.rd       = rd;
                idex_d.we       = writes_rd & (rd != '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign bus.id_valid    = idex_q.valid;
    assign bus.id_pc       = idex_q.pc;
    assign bus.id_opcode   = idex_q.opcode;
    assign bus.id_funct3   = idex_q.funct3;
    assign bus.id_funct7b5 = idex_q.funct7b5;
    assign bus.id_rs1_val  = idex_q.rs1_val;
    assign bus.id_rs2_val  = idex_q.rs2_val;
    assign bus.id_imm      = idex_q.imm;
    assign bus.id_rd       = idex_q.rd;
    assign bus.id_we       = idex_q.we;
endmodule
